// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 valid-only window generator
//
// Purpose:
//   Takes one signed pixel per handshake in raster order, keeps the two
//   previous rows in line buffers and presents every fully-populated 3x3
//   neighbourhood (no padding) to the convolution core.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   pix_in/pix_valid      input pixel stream; pix_ready is the back-pressure
//   pix_sof               marks the accepted pixel as (0,0) of a new frame
//   win_00..win_22        window element (row, col); win_22 is the newest pixel
//   win_valid/win_ready   window handshake towards the convolution core
//   frame_done            one-cycle pulse after the last pixel of a frame
`timescale 1ns/1ps
module conv_window_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  output logic                     pix_ready,
  output logic signed [DATA_W-1:0] win_00,
  output logic signed [DATA_W-1:0] win_01,
  output logic signed [DATA_W-1:0] win_02,
  output logic signed [DATA_W-1:0] win_10,
  output logic signed [DATA_W-1:0] win_11,
  output logic signed [DATA_W-1:0] win_12,
  output logic signed [DATA_W-1:0] win_20,
  output logic signed [DATA_W-1:0] win_21,
  output logic signed [DATA_W-1:0] win_22,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     cur_col;
  logic              accept;
  logic              emit;
  logic              last_pix;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;

  // lb1 holds row r-1, lb0 holds row r-2, both indexed by column.
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];

  assign pix_ready = !win_valid_q || win_ready;

  always_comb begin
    accept   = pix_valid && pix_ready;
    // A start-of-frame pixel is always column 0, whatever the counters say.
    cur_col  = pix_sof ? '0 : col_q;
    emit     = accept && !pix_sof && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
    last_pix = accept && !pix_sof && (row_q == ROW_LAST) && (col_q == COL_LAST);

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pix_sof) begin
        col_d = CW'(1);
        row_d = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // A new accept replaces the window (possibly with nothing, at columns 0/1);
    // otherwise a consumed window simply drops.
    win_valid_d = win_valid_q;
    if (accept) begin
      win_valid_d = emit;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end

    frame_done_d = last_pix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window shift register: left shift, new right column from the line buffers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb0_q[cur_col];
      win_q[1][2] <= lb1_q[cur_col];
      win_q[2][2] <= pix_in;
    end
  end

  // Line buffers are not reset: rows 0 and 1 of every frame rewrite them
  // completely before any window can be emitted.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      lb0_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= pix_in;
    end
  end

  assign win_00     = win_q[0][0];
  assign win_01     = win_q[0][1];
  assign win_02     = win_q[0][2];
  assign win_10     = win_q[1][0];
  assign win_11     = win_q[1][1];
  assign win_12     = win_q[1][2];
  assign win_20     = win_q[2][0];
  assign win_21     = win_q[2][1];
  assign win_22     = win_q[2][2];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen
`timescale 1ns/1ps
module tb_conv_window_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          win_ready = 1'b0;
  logic          pix_ready, win_valid, frame_done;
  logic [DW-1:0] win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22;
  wire  [71:0]   win_bus = {win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22};

  int            checks = 0;
  int            passed = 0;
  logic [71:0]   got_q[$];
  logic [71:0]   exp_q[$];
  int            got_fd = 0;
  int            exp_fd = 0;
  logic [7:0]    img [H][W];
  int            m_idx = 0;
  bit            rnd_on = 1'b0;

  typedef struct {
    logic [7:0]  pix;
    bit          sof;
    bit          exp_valid;
    bit          exp_fd;
    logic [71:0] exp_win;
  } vec_t;
  vec_t          tbl [16];
  logic [71:0]   s1_win [4];
  bit            vld [21];

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .win_00(win_00), .win_01(win_01), .win_02(win_02),
    .win_10(win_10), .win_11(win_11), .win_12(win_12),
    .win_20(win_20), .win_21(win_21), .win_22(win_22),
    .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: place each accepted pixel in a frame image by its raster index.
  task automatic model_push(input logic [7:0] p, input bit sof);
    int r, c;
    if (sof) m_idx = 0;
    r = m_idx / W;
    c = m_idx % W;
    img[r][c] = p;
    if (r >= 2 && c >= 2)
      exp_q.push_back({img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                       img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                       img[r][c-2],   img[r][c-1],   img[r][c]});
    if (m_idx == W*H-1) exp_fd++;
    m_idx = (m_idx + 1) % (W*H);
  endtask

  task automatic send(input logic [7:0] p, input bit sof);
    int guard;
    @(negedge clk);
    pix_in = p; pix_sof = sof; pix_valid = 1'b1;
    #1;
    guard = 0;
    while (!pix_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!pix_ready) begin
      chk("pix_ready_timeout", 72'(pix_ready), 72'(1));
      pix_valid = 1'b0; pix_sof = 1'b0;
    end else begin
      model_push(p, sof);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0; pix_sof = 1'b0;
    end
  endtask

  task automatic cmp_queues(input string name);
    chk({name, " win_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s win%0d", name, i), got_q[i], exp_q[i]);
    chk({name, " frame_done_count"}, 72'(got_fd), 72'(exp_fd));
    got_q.delete(); exp_q.delete(); got_fd = 0; exp_fd = 0;
  endtask

  // Window/frame_done monitor, sampled mid-cycle after the drivers have settled.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (win_valid && win_ready) got_q.push_back(win_bus);
      if (frame_done) begin
        got_fd++;
        chk("frame_done_with_win_valid", 72'(win_valid), 72'(1));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [71:0] v;
    int first;

    s1_win[0] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9,  8'd10, 8'd11};
    s1_win[1] = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
    s1_win[2] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    s1_win[3] = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
    for (int k = 0; k < 16; k++) begin
      tbl[k].pix = 8'(k + 1);
      tbl[k].sof = (k == 0);
      tbl[k].exp_valid = 1'b0;
      tbl[k].exp_fd = (k == 15);
      tbl[k].exp_win = '0;
    end
    tbl[10].exp_valid = 1'b1; tbl[10].exp_win = s1_win[0];
    tbl[11].exp_valid = 1'b1; tbl[11].exp_win = s1_win[1];
    tbl[14].exp_valid = 1'b1; tbl[14].exp_win = s1_win[2];
    tbl[15].exp_valid = 1'b1; tbl[15].exp_win = s1_win[3];

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset win_valid", 72'(win_valid), 72'(0));
    chk("reset frame_done", 72'(frame_done), 72'(0));
    chk("reset window", win_bus, 72'(0));
    reset = 1'b0;
    #1;
    chk("reset pix_ready", 72'(pix_ready), 72'(1));
    win_ready = 1'b1;

    // Scenario 1: table-driven 4x4 frame
    for (int k = 0; k < 16; k++) begin
      send(tbl[k].pix, tbl[k].sof);
      chk($sformatf("s1 win_valid px%0d", k + 1), 72'(win_valid), 72'(tbl[k].exp_valid));
      chk($sformatf("s1 frame_done px%0d", k + 1), 72'(frame_done), 72'(tbl[k].exp_fd));
      if (tbl[k].exp_valid) chk($sformatf("s1 window px%0d", k + 1), win_bus, tbl[k].exp_win);
    end
    idle(2);
    cmp_queues("s1");

    // Scenario 2: back-pressure after the first window
    fork
      begin
        for (int k = 1; k <= 16; k++) send(8'(k), k == 1);
        idle(1);
      end
      begin : s2_bp
        int g;
        g = 0;
        @(negedge clk);
        while (!win_valid && g < 100) begin @(negedge clk); g++; end
        chk("s2 first window seen", 72'(win_valid), 72'(1));
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          #1;
          chk("s2 hold pix_ready", 72'(pix_ready), 72'(0));
          chk("s2 hold win_valid", 72'(win_valid), 72'(1));
          chk("s2 hold window", win_bus, s1_win[0]);
          @(negedge clk);
        end
        win_ready = 1'b1;
      end
    join
    idle(2);
    for (int i = 0; i < 4; i++) begin
      v = (got_q.size() > i) ? got_q[i] : '0;
      chk($sformatf("s2 spec win%0d", i), v, s1_win[i]);
    end
    cmp_queues("s2");

    // Scenario 3: two back-to-back frames
    for (int k = 1; k <= 32; k++) send(8'(k), (k == 1) || (k == 17));
    idle(2);
    v = (got_q.size() > 4) ? got_q[4] : '0;
    chk("s3 frame2 first window", v,
        {8'd17, 8'd18, 8'd19, 8'd21, 8'd22, 8'd23, 8'd25, 8'd26, 8'd27});
    chk("s3 frame_done twice", 72'(got_fd), 72'(2));
    cmp_queues("s3");

    // Scenario 4: signed extremes
    for (int k = 0; k < 16; k++) send((k == 10) ? 8'h7F : 8'h80, k == 0);
    idle(2);
    v = (got_q.size() > 0) ? got_q[0] : '0;
    chk("s4 signed window", v, {{8{8'h80}}, 8'h7F});
    cmp_queues("s4");

    // Scenario 5: asynchronous reset mid-frame, then restart
    for (int k = 1; k <= 10; k++) send(8'(k), k == 1);
    #1;
    chk("s5 pre-reset win_22", 72'(win_22), 72'(10));
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
    #1;
    chk("s5 async reset window", win_bus, 72'(0));
    chk("s5 async reset win_valid", 72'(win_valid), 72'(0));
    chk("s5 async reset frame_done", 72'(frame_done), 72'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    got_q.delete(); exp_q.delete(); got_fd = 0; exp_fd = 0; m_idx = 0;
    for (int k = 1; k <= 16; k++) send(8'(k), k == 1);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      v = (got_q.size() > i) ? got_q[i] : '0;
      chk($sformatf("s5 restart win%0d", i), v, s1_win[i]);
    end
    cmp_queues("s5");

    // Scenario 6: mid-frame resync on the 6th pixel
    for (int k = 0; k < 21; k++) begin
      send(8'(100 + k), (k == 0) || (k == 5));
      vld[k] = win_valid;
    end
    idle(2);
    first = -1;
    for (int k = 20; k >= 0; k--) if (vld[k]) first = k;
    chk("s6 first window pixel from sof", 72'(first - 5 + 1), 72'(11));
    cmp_queues("s6");

    // Randomized stream with random back-pressure, gaps and resyncs
    rnd_on = 1'b1;
    fork
      begin
        send(8'($urandom), 1'b1);
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 4) == 0) idle(1);
          send(8'($urandom), $urandom_range(0, 39) == 0);
        end
        idle(1);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(negedge clk);
          win_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    win_ready = 1'b1;
    idle(3);
    cmp_queues("rnd");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming 3x3 window generator that feeds Conv2D_ReLU. It accepts one signed 8-bit pixel per handshake, in raster order (row-major, top-left first). Two line buffers hold the previous rows, and each valid-only (unpadded) 3x3 neighbourhood is presented on nine ports named to match the convolution core's input_feature_map_rc inputs. It is the producer side of the convolution core's window interface.

Parameters:
IMG_W, 8, image width in pixels; must be >= 3.
IMG_H, 8, image height in pixels; must be >= 3.
DATA_W, 8, pixel width in bits; pixels are signed two's complement.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
pix_in  input  DATA_W  signed input pixel
pix_valid  input  1  pix_in is valid this cycle
pix_sof  input  1  start of frame; qualified by pix_valid; marks the pixel as (0,0)
pix_ready  output  1  block can accept a pixel this cycle
win_00..win_22  output  DATA_W each (9 ports)  window element at row r, column c; win_22 is the newest pixel
win_valid  output  1  window outputs are valid
win_ready  input  1  downstream accepts the window
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - win_valid=0, frame_done=0, all win_* = 0.
  - Row and column counters = 0; pix_ready = 1 after reset deasserts.
  - Line buffer contents are not cleared, and this is safe: no window is formed until two fresh rows have been written.
- Pixel handshake:
  - pix_ready = !win_valid || win_ready (combinational).
  - Accept = pix_valid && pix_ready. Nothing advances without Accept.
- Position counters (col 0..IMG_W-1, row 0..IMG_H-1):
  - On Accept, col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
  - Accept with pix_sof=1: the pixel is treated as (0,0) and the counters go to (0,1), even mid-frame (resync). No window is emitted for it.
- Storage:
  - Two line buffers of IMG_W entries, indexed by col: lb1 holds row r-1, lb0 holds row r-2.
  - A 3x3 shift register holds the window.
  - On Accept at column c, all three columns shift left. The new right column is {lb0[c], lb1[c], pix_in}. Then lb0[c] <= lb1[c] and lb1[c] <= pix_in.
- Window emission:
  - An Accept at (r,c) with r>=2 and c>=2 sets win_valid=1 on the next edge.
  - Window contents: win_22 = pixel(r,c), win_00 = pixel(r-2,c-2).
  - Latency is 1 cycle from Accept to win_valid.
- Output hold and clear:
  - win_valid=1 && win_ready=0: all win_* and win_valid hold, and pix_ready=0.
  - win_valid && win_ready with no new qualifying Accept in the same cycle: win_valid clears next edge.
  - win_valid && win_ready with a qualifying Accept in the same cycle: win_valid stays 1 with the new data (back-to-back, no bubble).
- Per-frame output: (IMG_H-2)*(IMG_W-2) windows.
  - Columns 0 and 1 of every row produce no window; they only refill the shift register.
  - Row wrap therefore needs no flush logic.
- frame_done:
  - 1 on the edge after the Accept at (IMG_H-1, IMG_W-1); 0 otherwise.
  - Coincides with the last win_valid rising.
- Simultaneous events:
  - reset overrides everything.
  - pix_sof on the last pixel position: sof wins, and there is no frame_done.
- Arithmetic: pure data movement; sign is preserved, no arithmetic.

Test Plan:
1. IMG_W=IMG_H=4, pixels 1..16 streamed, win_ready=1, sof on pixel 1 -> exactly 4 windows, in this order:
   - (00..22) = 1,2,3,5,6,7,9,10,11
   - 2,3,4,6,7,8,10,11,12
   - 5,6,7,9,10,11,13,14,15
   - 6,7,8,10,11,12,14,15,16
   - frame_done pulses once, together with the 4th win_valid.
2. Same stream with win_ready held 0 for 5 cycles after the first window -> pix_ready=0 throughout, window 1,2,3,5,6,7,9,10,11 held stable, no pixel lost; the remaining windows match scenario 1.
3. Two back-to-back 4x4 frames, the second using values 17..32 with sof on 17 -> second-frame windows are 17,18,19,21,22,23,25,26,27 etc.; no window mixes data across the frame boundary; frame_done pulses twice.
4. Signed data: all pixels -128 except pixel(2,2)=127 -> first window is eight -128 values and win_22=127; sign is preserved.
5. Assert reset after pixel 10 of a 4x4 frame, then restart with sof at 1..16 -> outputs go to 0 immediately (asynchronously); the windows after restart are exactly those of scenario 1.
6. Resync: sof asserted on pixel 6 mid-frame, followed by 15 more pixels -> counters restart; the first window appears on the 11th pixel counted from the sof pixel.
